// File: rtl/div_seq.sv
// div_seq: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle over unsigned magnitudes, then a sign fixup.
// Optional feature macro: DIV_SEQ_EARLY_OUT_EN. When it is defined,
// divide-by-zero and signed overflow finish one cycle after accept.
//
// state  | meaning
// IDLE   | waiting for an accepted start
// DIVIDE | one restoring step per cycle, counter 0..XLEN-1
// FIXUP  | apply signs / divide-by-zero quotient, load result
// DONE   | done_o pulse; a new start may be accepted here
module div_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [4:0]      alu_ctrl_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;

    localparam logic [4:0] ALU_DIV  = 5'd18;
    localparam logic [4:0] ALU_DIVU = 5'd19;
    localparam logic [4:0] ALU_REM  = 5'd20;
    localparam logic [4:0] ALU_REMU = 5'd21;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_FIXUP  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t state_q, state_nxt;

    logic             is_div_op, in_signed, in_rem, a_neg, b_neg;
    logic [XLEN-1:0]  a_abs, b_abs;
    logic             accept, early_hit;

    logic             is_rem_q, q_neg_q, r_neg_q, divz_q;
    logic [XLEN-1:0]  divisor_q, rem_q, quo_q, result_q;
    logic [CNT_W-1:0] cnt_q;

    logic [XLEN:0]    shifted, diff;
    logic [XLEN-1:0]  quo_fix, rem_fix, fix_res;
    logic             load_fix;

`ifdef DIV_SEQ_EARLY_OUT_EN
    logic             divz_in, ovf_in;
    logic [XLEN-1:0]  early_res;
`endif

    // Opcode decode, operand magnitudes and the accept condition
    always_comb begin
        is_div_op = (alu_ctrl_i == ALU_DIV) || (alu_ctrl_i == ALU_DIVU) ||
                    (alu_ctrl_i == ALU_REM) || (alu_ctrl_i == ALU_REMU);
        in_signed = (alu_ctrl_i == ALU_DIV) || (alu_ctrl_i == ALU_REM);
        in_rem    = (alu_ctrl_i == ALU_REM) || (alu_ctrl_i == ALU_REMU);
        a_neg     = in_signed & op_a_i[XLEN-1];
        b_neg     = in_signed & op_b_i[XLEN-1];
        a_abs     = a_neg ? (~op_a_i + 1'b1) : op_a_i;
        b_abs     = b_neg ? (~op_b_i + 1'b1) : op_b_i;
        accept    = start_i & is_div_op & ~flush_i &
                    ((state_q == S_IDLE) || (state_q == S_DONE));
    end

`ifdef DIV_SEQ_EARLY_OUT_EN
    // Special cases resolved straight from the inputs, bypassing the iteration
    always_comb begin
        divz_in   = (op_b_i == '0);
        ovf_in    = in_signed & (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) & (op_b_i == '1);
        early_hit = accept & (divz_in | ovf_in);
        if (divz_in)
            early_res = in_rem ? op_a_i : '1;
        else
            early_res = in_rem ? '0 : op_a_i;
    end
`else
    // Every operation goes through the full iteration
    always_comb begin
        early_hit = 1'b0;
    end
`endif

    // One restoring step plus the sign / divide-by-zero fixup
    always_comb begin
        shifted  = {rem_q, quo_q[XLEN-1]};
        diff     = shifted - {1'b0, divisor_q};
        quo_fix  = divz_q ? '1 : (q_neg_q ? (~quo_q + 1'b1) : quo_q);
        rem_fix  = r_neg_q ? (~rem_q + 1'b1) : rem_q;
        fix_res  = is_rem_q ? rem_fix : quo_fix;
        load_fix = (state_q == S_FIXUP) & ~flush_i;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_nxt;
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (early_hit)
                    state_nxt = S_DONE;
                else if (accept)
                    state_nxt = S_DIVIDE;
                else
                    state_nxt = S_IDLE;
            end
            S_DIVIDE: begin
                if (cnt_q == CNT_W'(XLEN-1))
                    state_nxt = S_FIXUP;
            end
            S_FIXUP: state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush_i)
            state_nxt = S_IDLE;
    end

    // Outputs decoded from state
    always_comb begin
        busy_o   = (state_q == S_DIVIDE) || (state_q == S_FIXUP);
        done_o   = (state_q == S_DONE);
        stall_o  = busy_o | accept;
        result_o = result_q;
    end

    // Operand latch, iteration datapath and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            is_rem_q  <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            divz_q    <= 1'b0;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            if (accept) begin
                is_rem_q  <= in_rem;
                q_neg_q   <= a_neg ^ b_neg;
                r_neg_q   <= a_neg;
                divz_q    <= (op_b_i == '0);
                divisor_q <= b_abs;
                rem_q     <= '0;
                quo_q     <= a_abs;
                cnt_q     <= '0;
            end else if (state_q == S_DIVIDE) begin
                cnt_q <= cnt_q + 1'b1;
                if (!diff[XLEN]) begin
                    rem_q <= diff[XLEN-1:0];
                    quo_q <= {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_q <= shifted[XLEN-1:0];
                    quo_q <= {quo_q[XLEN-2:0], 1'b0};
                end
            end
            if (load_fix)
                result_q <= fix_res;
`ifdef DIV_SEQ_EARLY_OUT_EN
            else if (early_hit)
                result_q <= early_res;
`endif
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: randomized and directed checks of div_seq against a
// plain-arithmetic reference model. Honours DIV_SEQ_EARLY_OUT_EN.
module tb_div_seq;

    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_DIV  = 5'd18;
    localparam logic [4:0] OP_DIVU = 5'd19;
    localparam logic [4:0] OP_REM  = 5'd20;
    localparam logic [4:0] OP_REMU = 5'd21;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic [4:0]  alu_ctrl_i = 5'd0;
    logic [31:0] op_a_i = '0;
    logic [31:0] op_b_i = '0;
    logic        flush_i = 1'b0;
    logic        busy_o, stall_o, done_o;
    logic [31:0] result_o;

    int n_cmp = 0;
    int n_err = 0;

    div_seq #(.XLEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_i),
        .alu_ctrl_i (alu_ctrl_i),
        .op_a_i     (op_a_i),
        .op_b_i     (op_b_i),
        .flush_i    (flush_i),
        .busy_o     (busy_o),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .result_o   (result_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // RISC-V M-extension semantics, plain arithmetic
    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            OP_DIV:  begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return MIN_NEG;
                return sa / sb;
            end
            OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:  begin
                if (b == 0) return a;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bit special;
        special = (b == 0) ||
                  ((op == OP_DIV || op == OP_REM) && a == MIN_NEG && b == 32'hFFFF_FFFF);
`ifdef DIV_SEQ_EARLY_OUT_EN
        return special ? 1 : 34;
`else
        return special ? 34 : 34;
`endif
    endfunction

    // Called at a negedge: present a start and confirm it stalls (accept)
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        start_i    = 1'b1;
        alu_ctrl_i = op;
        op_a_i     = a;
        op_b_i     = b;
        #1;
        chk("stall_on_accept", {31'd0, stall_o}, 32'd1);
    endtask

    // Counts cycles after the accept edge until done_o, sampling at negedges
    task automatic wait_done(input string tag, input logic [4:0] op, input logic [31:0] a,
                             input logic [31:0] b, input bit poke);
        int n = 0;
        int busy_n = 0;
        bit seen = 0;
        int lat;
        lat = latency(op, a, b);
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) start_i = 1'b0;
            if (poke && n == 5) begin
                start_i    = 1'b1;
                alu_ctrl_i = OP_DIVU;
                op_a_i     = 32'd999;
                op_b_i     = 32'd3;
            end
            if (poke && n == 6) start_i = 1'b0;
            if (done_o) seen = 1;
            else if (busy_o) busy_n++;
        end
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_result"}, result_o, model(op, a, b));
        chk({tag, "_busy_cycles"}, busy_n, lat - 1);
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b);
        wait_done(tag, op, a, b, 1'b0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, done_o}, 32'd0);
    endtask

    task automatic count_done(input string tag, input int cycles);
        int pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done_o) pulses++;
        end
        chk(tag, pulses, 0);
    endtask

    initial begin
        logic [31:0] held;
        logic [4:0]  rop;
        logic [31:0] ra, rb;

        // reset with a valid start held: reset wins
        start_i = 1'b1; alu_ctrl_i = OP_DIVU; op_a_i = 32'd10; op_b_i = 32'd2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_result", result_o, 32'd0);
        start_i = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);

        // directed cases
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7);
        run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("div_by_zero", OP_DIV, 32'd5, 32'd0);
        run_op("remu_by_zero", OP_REMU, 32'd5, 32'd0);
        run_op("rem_neg_by_zero", OP_REM, 32'hFFFF_FFF0, 32'd0);
        run_op("div_ovf", OP_DIV, MIN_NEG, 32'hFFFF_FFFF);
        run_op("rem_ovf", OP_REM, MIN_NEG, 32'hFFFF_FFFF);
        run_op("divu_max", OP_DIVU, 32'hFFFF_FFFF, 32'd1);

        // non-divide opcode is ignored
        held = result_o;
        start_i = 1'b1; alu_ctrl_i = OP_SUB; op_a_i = 32'd9; op_b_i = 32'd3;
        #1;
        chk("sub_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        start_i = 1'b0;
        chk("sub_busy", {31'd0, busy_o}, 32'd0);
        count_done("sub_no_done", 40);
        chk("sub_result_kept", result_o, held);

        // flush beats a simultaneous start
        start_i = 1'b1; flush_i = 1'b1; alu_ctrl_i = OP_DIVU; op_a_i = 32'd50; op_b_i = 32'd5;
        #1;
        chk("flush_start_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        chk("flush_start_busy", {31'd0, busy_o}, 32'd0);

        // flush mid-divide at k+10
        held = result_o;
        issue(OP_DIVU, 32'd1234, 32'd11);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) start_i = 1'b0;
            if (n == 10) flush_i = 1'b1;
        end
        @(negedge clk);
        flush_i = 1'b0;
        chk("flush_busy", {31'd0, busy_o}, 32'd0);
        chk("flush_done", {31'd0, done_o}, 32'd0);
        count_done("flush_no_done", 40);
        chk("flush_result_kept", result_o, held);

        // reset mid-operation discards it
        issue(OP_DIV, 32'd777, 32'd7);
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 1) start_i = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        chk("midrst_result", result_o, 32'd0);
        count_done("midrst_no_done", 40);

        // back-to-back: second start in the DONE cycle, with an ignored poke while busy
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done("b2b_first", OP_DIVU, 32'd100, 32'd7, 1'b0);
        issue(OP_DIV, 32'hFFFF_FF00, 32'd9);
        wait_done("b2b_second", OP_DIV, 32'hFFFF_FF00, 32'd9, 1'b1);
        @(negedge clk);
        chk("b2b_done_pulse", {31'd0, done_o}, 32'd0);

        // randomized operations
        for (int i = 0; i < 60; i++) begin
            int mode;
            rop  = 5'd18 + 5'($urandom_range(0, 3));
            ra   = $urandom;
            mode = $urandom_range(0, 9);
            case (mode)
                0: rb = 32'd0;
                1: begin rb = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) ra = MIN_NEG; end
                2: rb = $urandom_range(1, 15);
                3: begin rb = $urandom; ra = $urandom_range(0, 100); end
                4: rb = -($urandom_range(1, 100));
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d", i), rop, ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
